colocador_ficha: RTL and testbench

Move-placement controller for the Connect Four datapath. It accepts a column choice and drops the current player's piece into the lowest free row of that column. It keeps one occupancy bitmap per player and alternates turns. It sits directly upstream of `Ganador`: it drives `Ganador`'s `jugador` and `board` inputs, then consumes its combinational `ganador` result to end the game on a win or a draw.

---
 rtl/tablero_pkg.sv | 26 ++
 rtl/colocador_ficha.sv | 215 +++++++++++++++++++++
 tb/tb_colocador_ficha.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tablero_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tablero_pkg
//  Purpose  : Shared board geometry, board bitmap type and controller
//             state encoding for the Connect Four datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package tablero_pkg;

    localparam int ROWS      = 6;
    localparam int COLS      = 7;
    localparam int MAX_MOVES = ROWS * COLS;

    // One bit per cell, row 0 is the bottom of the board
    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_PLACE = 3'd2,
        ST_CHECK = 3'd3,
        ST_END   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/colocador_ficha.sv
`default_nettype none
// ============================================================================
//  Module   : colocador_ficha
//  Purpose  : Move-placement controller. Accepts a column, drops the current
//             player's piece into the lowest free row, keeps one occupancy
//             bitmap per player, alternates turns and ends the game on the
//             external win flag or on a full board.
//  Options  : PLAY_TIMEOUT_EN - forfeit the turn after TIMEOUT_CYCLES idle
//             cycles in WAIT; when undefined `timeout` is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module colocador_ficha
    import tablero_pkg::*;
#(
    parameter int rows           = ROWS,
    parameter int columns        = COLS,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          col_valid,
    input  logic [2:0]                    col_sel,
    output logic                          col_ready,
    output logic                          col_err,
    output logic                          jugador,
    output logic [rows-1:0][columns-1:0]  board_j0,
    output logic [rows-1:0][columns-1:0]  board_j1,
    output logic [rows-1:0][columns-1:0]  board_chk,
    input  logic                          ganador_in,
    output logic                          game_over,
    output logic                          winner_valid,
    output logic                          winner,
    output logic                          draw,
    output logic                          timeout
);

    localparam int ROW_W      = (rows > 1) ? $clog2(rows) : 1;
    localparam int FULL_MOVES = rows * columns;

    state_t                       r_state;
    state_t                       w_next;
    logic [2:0]                   r_col;
    logic [ROW_W-1:0]             r_row;
    logic [5:0]                   r_moves;
    logic [rows-1:0][columns-1:0] w_occ;
    logic                         w_col_bad;
    logic                         w_cell_busy;
    logic                         w_accept;

    assign w_occ     = board_j0 | board_j1;
    assign board_chk = jugador ? board_j1 : board_j0;
    assign w_accept  = (r_state == ST_WAIT) && col_valid && !w_col_bad;

    // Reject out-of-range columns and columns whose top cell is taken
    always_comb begin
        w_col_bad = 1'b1;
        for (int c = 0; c < columns; c++) begin
            if (col_sel == 3'(c)) begin
                w_col_bad = w_occ[rows-1][c];
            end
        end
    end

    // Occupancy of the cell currently addressed by the scan pointer
    always_comb begin
        w_cell_busy = 1'b0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < columns; c++) begin
                if ((r_row == ROW_W'(r)) && (r_col == 3'(c))) begin
                    w_cell_busy = w_occ[r][c];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_next    = r_state;
        col_ready = 1'b0;
        game_over = 1'b0;
        unique case (r_state)
            ST_WAIT: begin
                col_ready = 1'b1;
                if (w_accept) begin
                    w_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!w_cell_busy) begin
                    w_next = ST_PLACE;
                end
            end
            ST_PLACE: begin
                w_next = ST_CHECK;
            end
            ST_CHECK: begin
                // ganador_in is combinational from board_chk, already updated here
                if (ganador_in || (r_moves == 6'(FULL_MOVES))) begin
                    w_next = ST_END;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_END: begin
                game_over = 1'b1;
            end
            default: begin
                w_next = ST_WAIT;
            end
        endcase
    end

`ifdef PLAY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
`endif

    // Datapath: request latch, row scan, bitmaps, move counter, turn and result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            col_err      <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_moves      <= '0;
            board_j0     <= '0;
            board_j1     <= '0;
            jugador      <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= 1'b0;
            draw         <= 1'b0;
`ifdef PLAY_TIMEOUT_EN
            timeout      <= 1'b0;
            r_to_cnt     <= '0;
`endif
        end else begin
            col_err <= 1'b0;
`ifdef PLAY_TIMEOUT_EN
            timeout <= 1'b0;
            // Holding the counter at zero outside WAIT clears it on re-entry
            if (r_state != ST_WAIT) begin
                r_to_cnt <= '0;
            end
`endif
            case (r_state)
                ST_WAIT: begin
                    if (col_valid && w_col_bad) begin
                        col_err <= 1'b1;
                    end else if (col_valid) begin
                        r_col <= col_sel;
                        r_row <= '0;
                    end
`ifdef PLAY_TIMEOUT_EN
                    // An accepted request in the expiry cycle takes priority
                    if (w_accept) begin
                        r_to_cnt <= '0;
                    end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout  <= 1'b1;
                        jugador  <= ~jugador;
                        r_to_cnt <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
`endif
                end
                ST_SCAN: begin
                    // A free row exists: the top cell was checked on acceptance
                    if (w_cell_busy) begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end
                ST_PLACE: begin
                    for (int r = 0; r < rows; r++) begin
                        for (int c = 0; c < columns; c++) begin
                            if ((r_row == ROW_W'(r)) && (r_col == 3'(c))) begin
                                if (jugador) begin
                                    board_j1[r][c] <= 1'b1;
                                end else begin
                                    board_j0[r][c] <= 1'b1;
                                end
                            end
                        end
                    end
                    r_moves <= r_moves + 6'd1;
                end
                ST_CHECK: begin
                    if (ganador_in) begin
                        winner_valid <= 1'b1;
                        winner       <= jugador;
                    end else if (r_moves == 6'(FULL_MOVES)) begin
                        draw <= 1'b1;
                    end else begin
                        jugador <= ~jugador;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_colocador_ficha.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_colocador_ficha
//  Purpose  : Self-checking bench for colocador_ficha. A behavioural board
//             model predicts every move; a four-in-a-row detector stands in
//             for the Ganador sibling and drives ganador_in.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_colocador_ficha;

    logic             clk = 1'b0;
    logic             rst;
    logic             col_valid;
    logic [2:0]       col_sel;
    logic             col_ready;
    logic             col_err;
    logic             jugador;
    logic [5:0][6:0]  board_j0;
    logic [5:0][6:0]  board_j1;
    logic [5:0][6:0]  board_chk;
    logic             ganador_in;
    logic             game_over;
    logic             winner_valid;
    logic             winner;
    logic             draw;
    logic             timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [5:0][6:0] m_b0;
    logic [5:0][6:0] m_b1;
    bit              m_turn;
    bit              m_over;
    bit              m_winner;
    bit              m_draw;
    int              m_moves;

    always #5 clk = ~clk;

    colocador_ficha #(
        .rows           (6),
        .columns        (7),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .col_valid    (col_valid),
        .col_sel      (col_sel),
        .col_ready    (col_ready),
        .col_err      (col_err),
        .jugador      (jugador),
        .board_j0     (board_j0),
        .board_j1     (board_j1),
        .board_chk    (board_chk),
        .ganador_in   (ganador_in),
        .game_over    (game_over),
        .winner_valid (winner_valid),
        .winner       (winner),
        .draw         (draw),
        .timeout      (timeout)
    );

    // Four of one player's pieces in a line, any direction
    function automatic bit four_in_row(input logic [5:0][6:0] b);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 7; c++) begin
                for (int d = 0; d < 4; d++) begin
                    int n = 0;
                    for (int k = 0; k < 4; k++) begin
                        int rr = r + k * dr[d];
                        int cc = c + k * dc[d];
                        if (rr >= 0 && rr < 6 && cc >= 0 && cc < 7) begin
                            if (b[rr][cc] === 1'b1) n++;
                        end
                    end
                    if (n == 4) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    assign ganador_in = four_in_row(board_chk);

    function automatic int free_row(input int col);
        logic [5:0][6:0] occ;
        logic [6:0]      rowv;
        occ = m_b0 | m_b1;
        if (col < 0 || col > 6) return -1;
        for (int r = 0; r < 6; r++) begin
            rowv = occ[r];
            if (!rowv[col]) return r;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_b0 = '0; m_b1 = '0; m_turn = 1'b0; m_over = 1'b0;
        m_winner = 1'b0; m_draw = 1'b0; m_moves = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; col_valid = 1'b0; col_sel = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One request, checked cycle by cycle against the model
    task automatic do_move(input int col);
        int h;
        bit win;
        checks++;
        if (col_ready !== !m_over) begin
            failures++; $display("FAIL ready_before_req: got %0b expected %0b", col_ready, !m_over);
        end
        col_valid = 1'b1; col_sel = 3'(col);
        @(negedge clk);
        col_valid = 1'b0;
        if (m_over) begin
            repeat (3) @(negedge clk);
            checks++;
            if ({game_over, col_ready, col_err, board_j1, board_j0} !== {1'b1, 1'b0, 1'b0, m_b1, m_b0}) begin
                failures++; $display("FAIL ignored_after_end: got go=%0b rdy=%0b err=%0b b1=%h b0=%h expected go=1 rdy=0 err=0 b1=%h b0=%h",
                                     game_over, col_ready, col_err, board_j1, board_j0, m_b1, m_b0);
            end
            return;
        end
        h = free_row(col);
        if (h < 0) begin
            checks++;
            if ({col_err, col_ready, jugador, board_j1, board_j0} !== {1'b1, 1'b1, m_turn, m_b1, m_b0}) begin
                failures++; $display("FAIL reject col=%0d: got err=%0b rdy=%0b jug=%0b b1=%h b0=%h expected err=1 rdy=1 jug=%0b b1=%h b0=%h",
                                     col, col_err, col_ready, jugador, board_j1, board_j0, m_turn, m_b1, m_b0);
            end
            @(negedge clk);
            checks++;
            if (col_err !== 1'b0) begin
                failures++; $display("FAIL err_pulse_width: got %0b expected 0", col_err);
            end
            return;
        end
        checks++;
        if ({col_err, col_ready} !== 2'b00) begin
            failures++; $display("FAIL scan_entry col=%0d: got err=%0b rdy=%0b expected 0 0", col, col_err, col_ready);
        end
        repeat (1 + h) @(negedge clk);   // PLACE cycle
        checks++;
        if ({board_j1, board_j0} !== {m_b1, m_b0}) begin
            failures++; $display("FAIL early_update col=%0d h=%0d: got b1=%h b0=%h expected b1=%h b0=%h",
                                 col, h, board_j1, board_j0, m_b1, m_b0);
        end
        if (m_turn) m_b1[h][col] = 1'b1; else m_b0[h][col] = 1'b1;
        m_moves++;
        @(negedge clk);                  // CHECK cycle
        checks++;
        if ({board_j1, board_j0, jugador, col_ready} !== {m_b1, m_b0, m_turn, 1'b0}) begin
            failures++; $display("FAIL placed col=%0d h=%0d: got b1=%h b0=%h jug=%0b rdy=%0b expected b1=%h b0=%h jug=%0b rdy=0",
                                 col, h, board_j1, board_j0, jugador, col_ready, m_b1, m_b0, m_turn);
        end
        win = four_in_row(m_turn ? m_b1 : m_b0);
        if (win) begin
            m_over = 1'b1; m_winner = m_turn;
        end else if (m_moves == 42) begin
            m_over = 1'b1; m_draw = 1'b1;
        end else begin
            m_turn = ~m_turn;
        end
        @(negedge clk);                  // first cycle after CHECK
        checks++;
        if ({game_over, col_ready, winner_valid, draw, jugador} !== {m_over, !m_over, win, m_draw, m_turn}
            || (win && winner !== m_winner)) begin
            failures++; $display("FAIL result col=%0d: got go=%0b rdy=%0b wv=%0b w=%0b dr=%0b jug=%0b expected go=%0b rdy=%0b wv=%0b w=%0b dr=%0b jug=%0b",
                                 col, game_over, col_ready, winner_valid, winner, draw, jugador,
                                 m_over, !m_over, win, m_winner, m_draw, m_turn);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({col_ready, board_j0, board_j1, jugador, col_err, game_over, winner_valid, winner, draw, timeout}
            !== {1'b1, 42'd0, 42'd0, 7'd0}) begin
            failures++; $display("FAIL reset_values: got rdy=%0b b0=%h b1=%h jug=%0b err=%0b go=%0b wv=%0b w=%0b dr=%0b to=%0b expected rdy=1 rest 0",
                                 col_ready, board_j0, board_j1, jugador, col_err, game_over, winner_valid, winner, draw, timeout);
        end
    endtask

    task automatic test_first_move();
        apply_reset();
        do_move(3);
        checks++;
        if ({board_j0[0][3], jugador, col_ready} !== 3'b111) begin
            failures++; $display("FAIL first_move: got cell=%0b jug=%0b rdy=%0b expected 1 1 1",
                                 board_j0[0][3], jugador, col_ready);
        end
    endtask

    task automatic test_column_full();
        apply_reset();
        for (int i = 0; i < 6; i++) do_move(2);
        do_move(2);
        checks++;
        if ({jugador, board_j0[5][2], board_j1[5][2]} !== 3'b001) begin
            failures++; $display("FAIL column_full_state: got jug=%0b top0=%0b top1=%0b expected 0 0 1",
                                 jugador, board_j0[5][2], board_j1[5][2]);
        end
    endtask

    task automatic test_bad_column();
        apply_reset();
        do_move(1);
        do_move(7);
        do_move(0);
    endtask

    task automatic test_win();
        int seq[7] = '{0, 6, 1, 6, 2, 6, 3};
        apply_reset();
        foreach (seq[i]) do_move(seq[i]);
        checks++;
        if ({winner_valid, winner, game_over, draw} !== 4'b1010) begin
            failures++; $display("FAIL win_flags: got wv=%0b w=%0b go=%0b dr=%0b expected 1 0 1 0",
                                 winner_valid, winner, game_over, draw);
        end
        do_move(4);
        do_move(5);
        repeat (5) @(negedge clk);
        checks++;
        if ({game_over, winner_valid, col_ready} !== 3'b110) begin
            failures++; $display("FAIL win_sticky: got go=%0b wv=%0b rdy=%0b expected 1 1 0",
                                 game_over, winner_valid, col_ready);
        end
    endtask

    // Column types A A B B A A B: A has player 0 on even rows, B on odd rows
    task automatic test_draw();
        int q[$];
        int pairs[3][2] = '{'{0, 2}, '{1, 3}, '{4, 6}};
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            q.push_back(pairs[p][0]);
            repeat (6) q.push_back(pairs[p][1]);
            repeat (5) q.push_back(pairs[p][0]);
        end
        repeat (6) q.push_back(5);
        foreach (q[i]) do_move(q[i]);
        checks++;
        if ({draw, winner_valid, game_over, board_j0 | board_j1} !== {3'b101, {42{1'b1}}}) begin
            failures++; $display("FAIL draw_flags: got dr=%0b wv=%0b go=%0b occ=%h expected 1 0 1 full",
                                 draw, winner_valid, game_over, board_j0 | board_j1);
        end
        do_move(3);
    endtask

    task automatic test_reset_mid_scan();
        apply_reset();
        do_move(4);
        do_move(4);
        col_valid = 1'b1; col_sel = 3'd4;
        @(negedge clk);
        col_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({board_j0, board_j1, jugador, col_ready, game_over} !== {84'd0, 3'b010}) begin
            failures++; $display("FAIL reset_mid_scan: got b0=%h b1=%h jug=%0b rdy=%0b go=%0b expected 0 0 0 1 0",
                                 board_j0, board_j1, jugador, col_ready, game_over);
        end
        do_move(4);
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        apply_reset();
`ifdef PLAY_TIMEOUT_EN
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) seen = 1'b1;
        end
        checks++;
        if ({seen, jugador} !== 2'b11) begin
            failures++; $display("FAIL timeout_pulse: got seen=%0b jug=%0b expected 1 1", seen, jugador);
        end
`else
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (timeout !== 1'b0) seen = 1'b1;
        end
        checks++;
        if ({seen, jugador, col_ready} !== 3'b001) begin
            failures++; $display("FAIL no_timeout: got seen=%0b jug=%0b rdy=%0b expected 0 0 1", seen, jugador, col_ready);
        end
`endif
    endtask

    task automatic test_random_games(input int games);
        for (int g = 0; g < games; g++) begin
            apply_reset();
            for (int n = 0; n < 80 && !m_over; n++) begin
                do_move(int'($urandom_range(0, 7)));
            end
            do_move(int'($urandom_range(0, 6)));
        end
    endtask

    initial begin
        rst = 1'b1; col_valid = 1'b0; col_sel = 3'd0;
        model_reset();
        test_reset();
        test_first_move();
        test_column_full();
        test_bad_column();
        test_win();
        test_draw();
        test_reset_mid_scan();
        test_timeout();
        test_random_games(6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
